// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall control, branch flush, halt handling and
// operand forward selection for a five-stage pipeline.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined;
// otherwise Stall_Count and Flush_Count are tied to zero.

module hazard_fwd_unit #(
   parameter int unsigned AW       = 5,
   parameter int unsigned LOAD_LAT = 1,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             Clock,
   input  logic             Reset_,
   input  logic             Valid_ID,
   input  logic [AW-1:0]    Rs_ID,
   input  logic [AW-1:0]    Rt_ID,
   input  logic             Uses_Rs_ID,
   input  logic             Uses_Rt_ID,
   input  logic [AW-1:0]    WriteAddr_EX,
   input  logic [AW-1:0]    WriteAddr_MEM,
   input  logic [AW-1:0]    WriteAddr_WB,
   input  logic             RegWrite_EX,
   input  logic             RegWrite_MEM,
   input  logic             RegWrite_WB,
   input  logic             MemRead_EX,
   input  logic             Branch_ID,
   input  logic             Halt_Req,
   output logic [1:0]       Fwd_Rs_Sel,
   output logic [1:0]       Fwd_Rt_Sel,
   output logic             PC_Stall,
   output logic             ID_Stall,
   output logic             EX_Bubble,
   output logic             IF_Flush,
   output logic             Halted,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count
);

   localparam int unsigned LC_W = 2;
   // Extra stall cycles after the detect cycle; zero means the detect cycle alone suffices.
   localparam logic [LC_W-1:0] LAT_RELOAD = LC_W'(LOAD_LAT - 1);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      HALT    = 2'd2
   } state_t;

   state_t          state;
   logic [LC_W-1:0] lat_cnt;
   logic            load_use;
   logic            stall_c;
   logic            flush_c;
   logic            halted_c;

   // A stage forwards only a real, nonzero write to a register the ID instruction reads.
   function automatic logic stage_hit(input logic we, input logic [AW-1:0] dst,
                                      input logic [AW-1:0] src, input logic used);
      return we & used & (dst != '0) & (dst == src);
   endfunction

   // Nearest producing stage wins: EX, then MEM, then WB.
   function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input logic used);
      if (stage_hit(RegWrite_EX, WriteAddr_EX, src, used))
         return 2'd1;
      else if (stage_hit(RegWrite_MEM, WriteAddr_MEM, src, used))
         return 2'd2;
      else if (stage_hit(RegWrite_WB, WriteAddr_WB, src, used))
         return 2'd3;
      else
         return 2'd0;
   endfunction

   // Load in EX whose destination is read by the instruction in ID.
   always_comb begin
      load_use = Valid_ID & MemRead_EX & RegWrite_EX & (WriteAddr_EX != '0) &
                 ((Uses_Rs_ID & (Rs_ID == WriteAddr_EX)) |
                  (Uses_Rt_ID & (Rt_ID == WriteAddr_EX)));
   end

   // Pipeline controls from current state and inputs; a pending stall masks the branch flush.
   always_comb begin
      stall_c  = 1'b0;
      flush_c  = 1'b0;
      halted_c = 1'b0;
      case (state)
         RUN: begin
            if (load_use)
               stall_c = 1'b1;
            else if (Branch_ID)
               flush_c = 1'b1;
         end
         LDSTALL: stall_c = 1'b1;
         HALT: begin
            stall_c  = 1'b1;
            halted_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset low forces every control low immediately, whatever the inputs are doing.
   assign PC_Stall  = stall_c & Reset_;
   assign ID_Stall  = stall_c & Reset_;
   assign EX_Bubble = stall_c & Reset_;
   assign IF_Flush  = flush_c & Reset_;
   assign Halted    = halted_c & Reset_;

   // State, stall down-counter and registered forward selects.
   always_ff @(posedge Clock or negedge Reset_) begin
      if (!Reset_) begin
         state      <= RUN;
         lat_cnt    <= '0;
         Fwd_Rs_Sel <= 2'd0;
         Fwd_Rt_Sel <= 2'd0;
      end else begin
         case (state)
            RUN: begin
               if (load_use) begin
                  lat_cnt <= LAT_RELOAD;
                  state   <= (LAT_RELOAD == '0) ? RUN : LDSTALL;
               end else if (!Branch_ID && Halt_Req) begin
                  state <= HALT;
               end
            end
            LDSTALL: begin
               // lat_cnt counts stall cycles still owed, including this one.
               lat_cnt <= lat_cnt - LC_W'(1);
               if (lat_cnt <= LC_W'(1))
                  state <= RUN;
            end
            HALT: begin
               if (!Halt_Req)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase

         if (stall_c || !Valid_ID) begin
            Fwd_Rs_Sel <= 2'd0;
            Fwd_Rt_Sel <= 2'd0;
         end else begin
            Fwd_Rs_Sel <= fwd_sel(Rs_ID, Uses_Rs_ID);
            Fwd_Rt_Sel <= fwd_sel(Rt_ID, Uses_Rt_ID);
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Saturating counts of non-halt stall cycles and flush cycles.
   always_ff @(posedge Clock or negedge Reset_) begin
      if (!Reset_) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_c && (state != HALT) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_c && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign Stall_Count = stall_cnt;
   assign Flush_Count = flush_cnt;
`else
   assign Stall_Count = '0;
   assign Flush_Count = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: drives one stimulus stream into two instances
// (LOAD_LAT=1 and LOAD_LAT=3) and checks both against a cycle-level model.

module tb_hazard_fwd_unit;

   localparam int AW = 5;
`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic          Clock = 1'b0;
   logic          Reset_ = 1'b1;
   logic          Valid_ID, Uses_Rs_ID, Uses_Rt_ID;
   logic [AW-1:0] Rs_ID, Rt_ID, WriteAddr_EX, WriteAddr_MEM, WriteAddr_WB;
   logic          RegWrite_EX, RegWrite_MEM, RegWrite_WB, MemRead_EX, Branch_ID, Halt_Req;

   logic [1:0]    fwd_rs [2];
   logic [1:0]    fwd_rt [2];
   logic          pc_st [2];
   logic          id_st [2];
   logic          ex_bb [2];
   logic          if_fl [2];
   logic          hlt_o [2];
   logic [15:0]   sc1, fc1;
   logic [3:0]    sc3, fc3;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state per instance
   int lat  [2] = '{1, 3};
   int cmax [2] = '{65535, 15};
   int rem  [2];
   bit hmod [2];
   int e_rs [2];
   int e_rt [2];
   int e_sc [2];
   int e_fc [2];
   bit e_st [2];
   bit e_fl [2];
   bit e_h  [2];

   always #5 Clock = ~Clock;

   hazard_fwd_unit #(.AW(AW), .LOAD_LAT(1), .CNT_W(16)) u_dut1 (
      .Clock(Clock), .Reset_(Reset_), .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
      .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID), .WriteAddr_EX(WriteAddr_EX),
      .WriteAddr_MEM(WriteAddr_MEM), .WriteAddr_WB(WriteAddr_WB), .RegWrite_EX(RegWrite_EX),
      .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB), .MemRead_EX(MemRead_EX),
      .Branch_ID(Branch_ID), .Halt_Req(Halt_Req), .Fwd_Rs_Sel(fwd_rs[0]), .Fwd_Rt_Sel(fwd_rt[0]),
      .PC_Stall(pc_st[0]), .ID_Stall(id_st[0]), .EX_Bubble(ex_bb[0]), .IF_Flush(if_fl[0]),
      .Halted(hlt_o[0]), .Stall_Count(sc1), .Flush_Count(fc1));

   hazard_fwd_unit #(.AW(AW), .LOAD_LAT(3), .CNT_W(4)) u_dut3 (
      .Clock(Clock), .Reset_(Reset_), .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
      .Uses_Rs_ID(Uses_Rs_ID), .Uses_Rt_ID(Uses_Rt_ID), .WriteAddr_EX(WriteAddr_EX),
      .WriteAddr_MEM(WriteAddr_MEM), .WriteAddr_WB(WriteAddr_WB), .RegWrite_EX(RegWrite_EX),
      .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB), .MemRead_EX(MemRead_EX),
      .Branch_ID(Branch_ID), .Halt_Req(Halt_Req), .Fwd_Rs_Sel(fwd_rs[1]), .Fwd_Rt_Sel(fwd_rt[1]),
      .PC_Stall(pc_st[1]), .ID_Stall(id_st[1]), .EX_Bubble(ex_bb[1]), .IF_Flush(if_fl[1]),
      .Halted(hlt_o[1]), .Stall_Count(sc3), .Flush_Count(fc3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] scnt(input int i);
      return (i == 0) ? 32'(sc1) : 32'(sc3);
   endfunction

   function automatic logic [31:0] fcnt(input int i);
      return (i == 0) ? 32'(fc1) : 32'(fc3);
   endfunction

   function automatic bit hit(input bit we, input int dst, input int src, input bit used);
      return we && used && (dst != 0) && (dst == src);
   endfunction

   function automatic int sel(input int src, input bit used);
      if (hit(RegWrite_EX, int'(WriteAddr_EX), src, used)) return 1;
      if (hit(RegWrite_MEM, int'(WriteAddr_MEM), src, used)) return 2;
      if (hit(RegWrite_WB, int'(WriteAddr_WB), src, used)) return 3;
      return 0;
   endfunction

   function automatic bit load_use();
      int w;
      w = int'(WriteAddr_EX);
      return Valid_ID && MemRead_EX && RegWrite_EX && (w != 0) &&
             ((Uses_Rs_ID && int'(Rs_ID) == w) || (Uses_Rt_ID && int'(Rt_ID) == w));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rem[i] = 0; hmod[i] = 0; e_rs[i] = 0; e_rt[i] = 0; e_sc[i] = 0; e_fc[i] = 0;
      end
   endtask

   task automatic idle();
      Valid_ID = 0; Uses_Rs_ID = 0; Uses_Rt_ID = 0; Rs_ID = '0; Rt_ID = '0;
      WriteAddr_EX = '0; WriteAddr_MEM = '0; WriteAddr_WB = '0;
      RegWrite_EX = 0; RegWrite_MEM = 0; RegWrite_WB = 0; MemRead_EX = 0;
      Branch_ID = 0; Halt_Req = 0;
   endtask

   // Called at a quiet point before the next rising edge; checks outputs on both sides of it.
   task automatic cyc();
      bit lu;
      #1;
      lu = load_use();
      for (int i = 0; i < 2; i++) begin
         e_h[i]  = hmod[i];
         e_st[i] = hmod[i] || (rem[i] > 0) || lu;
         e_fl[i] = !e_st[i] && Branch_ID;
         chk($sformatf("pc_stall[%0d]", i), 32'(pc_st[i]), 32'(e_st[i]));
         chk($sformatf("id_stall[%0d]", i), 32'(id_st[i]), 32'(e_st[i]));
         chk($sformatf("ex_bubble[%0d]", i), 32'(ex_bb[i]), 32'(e_st[i]));
         chk($sformatf("if_flush[%0d]", i), 32'(if_fl[i]), 32'(e_fl[i]));
         chk($sformatf("halted[%0d]", i), 32'(hlt_o[i]), 32'(e_h[i]));
      end
      @(posedge Clock);
      for (int i = 0; i < 2; i++) begin
         if (e_st[i] || !Valid_ID) begin
            e_rs[i] = 0; e_rt[i] = 0;
         end else begin
            e_rs[i] = sel(int'(Rs_ID), Uses_Rs_ID);
            e_rt[i] = sel(int'(Rt_ID), Uses_Rt_ID);
         end
         if (e_st[i] && !hmod[i] && e_sc[i] < cmax[i]) e_sc[i]++;
         if (e_fl[i] && e_fc[i] < cmax[i]) e_fc[i]++;
         if (hmod[i]) hmod[i] = Halt_Req;
         else if (rem[i] > 0) rem[i]--;
         else if (lu) rem[i] = lat[i] - 1;
         else if (!Branch_ID && Halt_Req) hmod[i] = 1;
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("fwd_rs[%0d]", i), 32'(fwd_rs[i]), 32'(e_rs[i]));
         chk($sformatf("fwd_rt[%0d]", i), 32'(fwd_rt[i]), 32'(e_rt[i]));
         chk($sformatf("stall_cnt[%0d]", i), scnt(i), PERF ? 32'(e_sc[i]) : 32'd0);
         chk($sformatf("flush_cnt[%0d]", i), fcnt(i), PERF ? 32'(e_fc[i]) : 32'd0);
      end
   endtask

   // Assert reset between edges and check everything drops at once.
   task automatic do_reset();
      Reset_ = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_pc_stall[%0d]", i), 32'(pc_st[i]), 32'd0);
         chk($sformatf("rst_id_stall[%0d]", i), 32'(id_st[i]), 32'd0);
         chk($sformatf("rst_ex_bubble[%0d]", i), 32'(ex_bb[i]), 32'd0);
         chk($sformatf("rst_if_flush[%0d]", i), 32'(if_fl[i]), 32'd0);
         chk($sformatf("rst_halted[%0d]", i), 32'(hlt_o[i]), 32'd0);
         chk($sformatf("rst_fwd_rs[%0d]", i), 32'(fwd_rs[i]), 32'd0);
         chk($sformatf("rst_fwd_rt[%0d]", i), 32'(fwd_rt[i]), 32'd0);
         chk($sformatf("rst_stall_cnt[%0d]", i), scnt(i), 32'd0);
         chk($sformatf("rst_flush_cnt[%0d]", i), fcnt(i), 32'd0);
      end
      model_reset();
      #3;
      Reset_ = 1'b1;
   endtask

   task automatic load_hazard_rs5();
      idle();
      Valid_ID = 1; Rs_ID = 5; Uses_Rs_ID = 1;
      RegWrite_EX = 1; MemRead_EX = 1; WriteAddr_EX = 5;
   endtask

   task automatic load_moved_to_mem();
      RegWrite_EX = 0; MemRead_EX = 0; WriteAddr_EX = '0;
      RegWrite_MEM = 1; WriteAddr_MEM = 5;
   endtask

   initial begin
      idle();
      #6;
      do_reset();

      // Load-use on Rs=5: one stall for LOAD_LAT=1, three for LOAD_LAT=3, then MEM forward
      load_hazard_rs5();
      cyc();
      load_moved_to_mem();
      cyc();
      chk("req026_fwd_rs_lat1", 32'(fwd_rs[0]), 32'd2);
      cyc();
      cyc();
      chk("req027_lat3_not_stalled", 32'(pc_st[1]), 32'd0);
      cyc();
      chk("req027_fwd_rs_lat3", 32'(fwd_rs[1]), 32'd2);
      chk("req027_stall_count_lat3", scnt(1), PERF ? 32'd3 : 32'd0);
      chk("req026_stall_count_lat1", scnt(0), PERF ? 32'd1 : 32'd0);

      // Rt=7 written by EX, MEM and WB: nearest wins
      idle();
      Valid_ID = 1; Rt_ID = 7; Uses_Rt_ID = 1;
      RegWrite_EX = 1; RegWrite_MEM = 1; RegWrite_WB = 1;
      WriteAddr_EX = 7; WriteAddr_MEM = 7; WriteAddr_WB = 7;
      cyc();
      chk("req028_fwd_rt_ex", 32'(fwd_rt[0]), 32'd1);
      RegWrite_EX = 0;
      cyc();
      chk("req028_fwd_rt_mem", 32'(fwd_rt[0]), 32'd2);
      RegWrite_MEM = 0;
      cyc();
      chk("req028_fwd_rt_wb", 32'(fwd_rt[1]), 32'd3);
      Uses_Rt_ID = 0;
      cyc();
      Valid_ID = 0; Uses_Rt_ID = 1;
      cyc();

      // r0 everywhere, including a load to r0: no forward, no stall
      idle();
      Valid_ID = 1; Uses_Rs_ID = 1; Uses_Rt_ID = 1;
      RegWrite_EX = 1; RegWrite_MEM = 1; RegWrite_WB = 1; MemRead_EX = 1;
      cyc();
      chk("req029_fwd_rs_r0", 32'(fwd_rs[0]), 32'd0);
      chk("req029_no_stall", 32'(e_st[1]), 32'(pc_st[1]));

      // Branch coinciding with a load-use stall is deferred
      do_reset();
      load_hazard_rs5();
      Branch_ID = 1;
      cyc();
      load_moved_to_mem();
      cyc();
      chk("req030_flush_count_lat1", fcnt(0), PERF ? 32'd1 : 32'd0);
      Branch_ID = 0;
      cyc();
      cyc();
      Branch_ID = 1;
      cyc();
      chk("req030_flush_count_lat3", fcnt(1), PERF ? 32'd1 : 32'd0);
      Branch_ID = 0;
      cyc();

      // Halt held four cycles, then reset during halt
      idle();
      Halt_Req = 1;
      repeat (4) cyc();
      chk("req031_halted", 32'(hlt_o[0]), 32'd1);
      do_reset();

      // Halt requested during a load stall waits for the stall to finish
      load_hazard_rs5();
      cyc();
      load_moved_to_mem();
      Halt_Req = 1;
      repeat (4) cyc();
      Halt_Req = 0;
      cyc();

      // Random traffic on a small register window
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         Valid_ID      = ($urandom_range(0, 7) != 0);
         Rs_ID         = AW'($urandom_range(0, 3));
         Rt_ID         = AW'($urandom_range(0, 3));
         Uses_Rs_ID    = 1'($urandom_range(0, 1));
         Uses_Rt_ID    = 1'($urandom_range(0, 1));
         WriteAddr_EX  = AW'($urandom_range(0, 3));
         WriteAddr_MEM = AW'($urandom_range(0, 3));
         WriteAddr_WB  = AW'($urandom_range(0, 3));
         RegWrite_EX   = 1'($urandom_range(0, 1));
         RegWrite_MEM  = 1'($urandom_range(0, 1));
         RegWrite_WB   = 1'($urandom_range(0, 1));
         MemRead_EX    = 1'($urandom_range(0, 1));
         Branch_ID     = ($urandom_range(0, 4) == 0);
         Halt_Req      = ($urandom_range(0, 5) == 0) ? ~Halt_Req : Halt_Req;
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter LOAD_LAT, default 1, legal 1..4, meaning load-use stall cycles.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-004 The block SHALL have ports as follows, one per line, in this order:
 Clock  in  1  single clock, rising edge.
 Reset_  in  1  asynchronous, active-low reset.
 Valid_ID  in  1  ID holds a real instruction.
 Rs_ID, Rt_ID  in  AW  ID source addresses.
 Uses_Rs_ID, Uses_Rt_ID  in  1  ID instruction reads Rs/Rt.
 WriteAddr_EX, WriteAddr_MEM, WriteAddr_WB  in  AW  destination per stage.
 RegWrite_EX, RegWrite_MEM, RegWrite_WB  in  1  stage writes register file.
 MemRead_EX  in  1  EX instruction is a load.
 Branch_ID  in  1  taken branch resolved in ID.
 Halt_Req  in  1  halt request.
 Fwd_Rs_Sel, Fwd_Rt_Sel  out  2  registered EX operand select.
 PC_Stall, ID_Stall, EX_Bubble, IF_Flush, Halted  out  1  pipeline controls.
 Stall_Count, Flush_Count  out  CNT_W  performance counters.

Function
REQ-005 The FSM SHALL have states RUN, LDSTALL, HALT.
REQ-006 Load-use SHALL be Valid_ID & MemRead_EX & RegWrite_EX & WriteAddr_EX!=0 & ((Uses_Rs_ID & Rs_ID==WriteAddr_EX) | (Uses_Rt_ID & Rt_ID==WriteAddr_EX)).
REQ-007 In RUN, on load-use the FSM SHALL enter LDSTALL and load a down-counter with LOAD_LAT-1.
REQ-008 PC_Stall, ID_Stall and EX_Bubble SHALL be 1 in the detect cycle and in every LDSTALL cycle, giving exactly LOAD_LAT stalled cycles.
REQ-009 LDSTALL SHALL return to RUN when the counter is 0; otherwise the counter SHALL decrement.
REQ-010 In RUN with no load-use, Branch_ID=1 SHALL assert IF_Flush for that cycle only.
REQ-011 If Branch_ID and load-use coincide, the stall SHALL win, IF_Flush SHALL stay 0, and the branch SHALL be re-evaluated after the stall.
REQ-012 In RUN with no load-use and no Branch_ID, Halt_Req=1 SHALL move the FSM to HALT at the next edge.
REQ-013 In HALT, PC_Stall=ID_Stall=EX_Bubble=Halted=1; Halt_Req=0 SHALL return the FSM to RUN at the next edge.
REQ-014 Halt_Req during LDSTALL SHALL be ignored until the FSM is back in RUN.
REQ-015 Forward select, evaluated in ID and registered at the edge, SHALL be 1 on EX match, else 2 on MEM match, else 3 on WB match, else 0.
REQ-016 A stage matches only when its RegWrite is 1, its address is nonzero and equals the source, and the source is used.
REQ-017 Address 0 SHALL never be forwarded.
REQ-018 When ID_Stall=1 or Valid_ID=0, the registered Fwd selects SHALL load 0, matching the bubble.
REQ-019 IF_Flush and the stall/halt outputs SHALL be combinational from the FSM state and current inputs.

Reset
REQ-020 Reset_=0 SHALL asynchronously force state RUN, counter 0, all outputs 0 and both counters 0, including mid-stall and mid-halt.
REQ-021 After Reset_ rises, the first edge SHALL evaluate normally.

Configuration
REQ-022 With HAZ_PERF_CNT_EN defined, Stall_Count SHALL increment per cycle with PC_Stall=1 outside HALT.
REQ-023 With HAZ_PERF_CNT_EN defined, Flush_Count SHALL increment per IF_Flush cycle.
REQ-024 Both counters SHALL saturate at all-ones.
REQ-025 Without HAZ_PERF_CNT_EN, both counter ports SHALL remain present and be tied to 0 with no counter logic.

Verification
REQ-026 LOAD_LAT=1, load to r5 in EX, ID uses Rs=5 -> one cycle of PC_Stall/ID_Stall/EX_Bubble=1, then Fwd_Rs_Sel=2 for the consumer.
REQ-027 LOAD_LAT=3, same hazard -> stall exactly 3 cycles; Stall_Count=3 with the macro, 0 without.
REQ-028 ALU writes r7 in EX, MEM and WB simultaneously, ID uses Rt=7 -> Fwd_Rt_Sel=1; with only WB writing r7 -> 3.
REQ-029 Writes to r0 in all stages, Rs=0 -> Fwd_Rs_Sel=0 and no stall, even if the EX instruction is a load to r0.
REQ-030 Branch_ID with load-use same cycle -> IF_Flush=0 during the stall, then 1 for one cycle after; Flush_Count=1.
REQ-031 Halt_Req held 4 cycles, then Reset_ pulsed low during HALT -> Halted=1 for 3 cycles, then all outputs 0 immediately on Reset_ low.
